down_timer: RTL

- Loadable down-counting timer: the decrementing counterpart of the team's free-running up-counter.
- Accepts a start value over a valid/ready load handshake and counts down to zero, one step per cycle.
- Signals expiry with a one-cycle done pulse and can optionally auto-reload.
- Used as a timeout/period source, and as a small formal benchmark with embedded properties.

---
 rtl/down_timer_pkg.sv | 12 +
 rtl/down_timer_if.sv | 24 ++
 rtl/down_timer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/down_timer_pkg.sv
// Shared types and constants for the loadable down-counting timer.
package down_timer_pkg;

   localparam int unsigned DEFAULT_W = 10;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_e;

endpackage

// File: rtl/down_timer_if.sv
// Load handshake, run controls and status of the down-counting timer.
interface down_timer_if #(
   parameter int unsigned W = down_timer_pkg::DEFAULT_W
);
   logic         load_valid;
   logic [W-1:0] load_value;
   logic         load_ready;
   logic         auto_reload;
   logic         pause;
   logic         abort;
   logic [W-1:0] count;
   logic         busy;
   logic         done;

   modport master (
      output load_valid, load_value, auto_reload, pause, abort,
      input  load_ready, count, busy, done
   );

   modport slave (
      input  load_valid, load_value, auto_reload, pause, abort,
      output load_ready, count, busy, done
   );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counting timer with one-cycle done pulse and optional auto-reload.
// Defining DOWN_TIMER_ASSERT_EN embeds formal properties; behaviour is unchanged.
//
// state | meaning
// IDLE  | waiting for a load; count is 0
// RUN   | decrementing one step per cycle toward expiry
// PAUSE | count held while pause is high
module down_timer
   import down_timer_pkg::*;
#(
   parameter int unsigned W = DEFAULT_W
) (
   input  logic       clk,
   input  logic       rst_n,
   down_timer_if.slave tif
);

   state_e       state_q,  state_d;
   logic [W-1:0] count_q,  count_d;
   logic [W-1:0] reload_q, reload_d;
   logic         done_q,   done_d;
   logic         load_ready;

   assign load_ready     = (state_q == IDLE);
   assign tif.load_ready = load_ready;
   assign tif.busy       = (state_q != IDLE);
   assign tif.count      = count_q;
   assign tif.done       = done_q;

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      done_d   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (tif.load_valid) begin
               if (tif.load_value != '0) begin
                  count_d  = tif.load_value;
                  reload_d = tif.load_value;
                  state_d  = RUN;
               end else begin
                  // Zero load expires at once without ever becoming busy.
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (tif.abort) begin
               count_d = '0;
               state_d = IDLE;
            end else if (tif.pause) begin
               state_d = PAUSE;
            end else if (count_q > W'(1)) begin
               count_d = count_q - W'(1);
            end else begin
               done_d = 1'b1;
               if (tif.auto_reload) begin
                  count_d = reload_q;
               end else begin
                  count_d = '0;
                  state_d = IDLE;
               end
            end
         end
         PAUSE: begin
            if (tif.abort) begin
               count_d = '0;
               state_d = IDLE;
            end else if (!tif.pause) begin
               state_d = RUN;
            end
         end
         default: begin
            count_d = '0;
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         reload_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         reload_q <= reload_d;
         done_q   <= done_d;
      end
   end

`ifdef DOWN_TIMER_ASSERT_EN
   state_e       prev_state_q;
   logic [W-1:0] prev_count_q;
   logic         prev_zero_load_q;
   logic         init_q;

   initial init_q = 1'b1;

   always @(posedge clk) init_q <= 1'b0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev_state_q     <= IDLE;
         prev_count_q     <= '0;
         prev_zero_load_q <= 1'b0;
      end else begin
         prev_state_q     <= state_q;
         prev_count_q     <= count_q;
         prev_zero_load_q <= tif.load_valid && load_ready && (tif.load_value == '0);
      end
   end

   always @* assume (!rst_n == init_q);

   always @(posedge clk) begin
      if (rst_n) begin
         assert (count_q <= reload_q);
         assert (!tif.busy || (count_q != '0));
         assert (!done_q || (prev_state_q == RUN && prev_count_q == W'(1)) || prev_zero_load_q);
         assert (!(state_q == IDLE && count_q != '0));
         assert (load_ready == !tif.busy);
      end
   end
`endif

endmodule
